// File: rtl/shift_ctrl_pkg.sv
// shift_ctrl_pkg: shared FSM state type and default frame width for the serializer
package shift_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/shift_seq_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter; on a tie the requester not granted last wins
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       valid_o,
    output logic       winner_o
);

    assign valid_o  = |req_i;
    assign winner_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];

endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: arbitrates two parallel requesters and serializes the winner's word MSB first
module shift_seq_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       ack,
    output logic             so,
    output logic             so_valid,
    output logic             grant_id,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       ack_q, ack_d;
    logic             grant_q, grant_d;
    logic             last_q, last_d;
    logic             arb_valid, arb_win;

    rr_arb2 u_arb (
        .req_i        (req),
        .last_grant_i (last_q),
        .valid_o      (arb_valid),
        .winner_o     (arb_win)
    );

    // capture on an idle request, then shift one bit per cycle until the last bit
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        ack_d   = 2'b00;
        grant_d = grant_q;
        last_d  = last_q;
        if (state_q == IDLE) begin
            if (arb_valid) begin
                state_d = SHIFT;
                shreg_d = arb_win ? data1 : data0;
                cnt_d   = '0;
                ack_d   = arb_win ? 2'b10 : 2'b01;
                grant_d = arb_win;
                last_d  = arb_win;
            end
        end else begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    // state registers; pointer resets to 1 so requester 0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ack_q   <= 2'b00;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    assign ack      = ack_q;
    assign so_valid = (state_q == SHIFT);
    assign so       = so_valid & shreg_q[WIDTH-1];
    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bits per serial frame (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port req, input, 2 bits: req[i] high means requester i has a word to send.
REQ-005 The block SHALL have ports data0 and data1, input, WIDTH bits each: the parallel words of requesters 0 and 1.
REQ-006 The block SHALL have port ack, output, 2 bits: a one-cycle pulse on ack[i] when requester i's word is captured.
REQ-007 The block SHALL have port so, output, 1 bit: the serial data, MSB first.
REQ-008 The block SHALL have port so_valid, output, 1 bit: high while so carries a frame bit.
REQ-009 The block SHALL have port grant_id, output, 1 bit: the requester owning the current or most recent frame.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have exactly two states, IDLE and SHIFT; the reset state SHALL be IDLE.
REQ-012 In IDLE with req==0, the block SHALL hold IDLE, with so=0 and so_valid=0.
REQ-013 In IDLE with req!=0 at edge E, the block SHALL pick a winner i, load the WIDTH-bit shift register from data_i, set grant_id=i and bit counter=0, and enter SHIFT.
REQ-014 Arbitration SHALL be round-robin: with a single requester, that requester wins; with both, the requester not served last wins; after reset, requester 0 wins the first tie.
REQ-015 ack[i] SHALL be registered: high for exactly the cycle after E, ack[1-i]=0, never both high at once.
REQ-016 In SHIFT, so SHALL equal shreg[WIDTH-1] and so_valid SHALL be 1; at each edge shreg SHALL shift left with 0 fill and the counter SHALL increment.
REQ-017 When counter==WIDTH-1 at an edge, the block SHALL return to IDLE, so the frame is exactly WIDTH so_valid cycles (E+1..E+WIDTH).
REQ-018 req, data0 and data1 SHALL be ignored in SHIFT; data SHALL be sampled only at the capture edge.
REQ-019 IDLE SHALL last at least one cycle between frames; back-to-back frame period SHALL be WIDTH+1 cycles.
REQ-020 A requester still holding req after its ack SHALL be treated as a new request and arbitrated normally.
REQ-021 The counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-022 While reset=0, asynchronously: state=IDLE, shreg=0, counter=0, so=0, so_valid=0, ack=0, grant_id=0, busy=0, and the round-robin pointer SHALL favour requester 0.
REQ-023 A reset mid-frame SHALL abort the frame with no further so_valid, and the aborted requester SHALL NOT be re-acked.
REQ-024 After reset deasserts, the first capture SHALL occur no earlier than the first rising edge with reset=1.

Structure
REQ-025 Package shift_ctrl_pkg SHALL hold the state enum (IDLE, SHIFT) and the default WIDTH constant.
REQ-026 Arbitration SHALL live in a sub-module rr_arb2 (inputs req[1:0] and last-grant; outputs valid and winner), instantiated once.

Verification
REQ-027 Single request: WIDTH=8, req=01, data0=8'hA5 -> ack=01 for 1 cycle; so=1,0,1,0,0,1,0,1 over 8 so_valid cycles; grant_id=0.
REQ-028 Tie after reset: req=11, data0=8'hF0, data1=8'h0F -> frame F0 (grant 0), one IDLE cycle, then frame 0F (grant 1); ack pulses 01, then 10.
REQ-029 Held request: req=10 held with data1=8'h81 -> repeated 81 frames with period 9 cycles and one ack per frame.
REQ-030 Mid-frame reset: reset=0 after bit 3 of an 8'hFF frame -> so=0, so_valid=0 and busy=0 immediately (asynchronously); no ack occurs during reset.
REQ-031 Data change during SHIFT: data0 changes from 8'h3C to 8'hFF after capture -> the serialized bits are still 3C.
REQ-032 Idle check: req=00 for 20 cycles -> so_valid, ack and busy stay 0.
